// File: rtl/regfile_writeback.sv
// regfile_writeback: regfile write-port driver merging ALU results and in-order load returns; optional REGFILE_WB_BYPASS_EN exposes next-cycle write as bypass
module regfile_writeback #(
  parameter int LDQ_DEPTH = 2,
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          alu_valid,
  output logic          alu_ready,
  input  logic [RW-1:0] alu_dest,
  input  logic [DW-1:0] alu_data,
  input  logic          ld_issue,
  output logic          ld_ready,
  input  logic [RW-1:0] ld_dest,
  input  logic [2:0]    ld_type,
  input  logic [1:0]    ld_lo,
  input  logic          mem_rvalid,
  input  logic [DW-1:0] mem_rdata,
  output logic          wren,
  output logic [RW-1:0] wr,
  output logic [DW-1:0] wd,
  output logic [31:0]   ld_busy,
  output logic          resp_err
`ifdef REGFILE_WB_BYPASS_EN
  ,
  output logic          byp_valid,
  output logic [RW-1:0] byp_reg,
  output logic [DW-1:0] byp_data
`endif
);
  localparam int PW = LDQ_DEPTH > 1 ? $clog2(LDQ_DEPTH) : 1;
  localparam int CW = $clog2(LDQ_DEPTH + 1);
  logic [RW-1:0]        q_dest [LDQ_DEPTH];
  logic [2:0]           q_type [LDQ_DEPTH];
  logic [1:0]           q_lo   [LDQ_DEPTH];
  logic [LDQ_DEPTH-1:0] q_v;
  logic [PW-1:0]        wp, rp, wp_n, rp_n;
  logic [CW-1:0]        cnt;
  logic                 push, pop, alu_acc, skid_v, skid_v_n, sel_v, nxt_wren;
  logic [RW-1:0]        skid_d, h_dest, sel_d;
  logic [DW-1:0]        skid_data, ld_val, sel_data;
  logic [2:0]           h_type;
  logic [1:0]           h_lo;
  logic [7:0]           byte_v;
  logic [15:0]          half_v;
  logic [31:0]          busy;
  always_comb begin
    ld_ready  = cnt < CW'(LDQ_DEPTH);
    alu_ready = !skid_v;
    alu_acc   = alu_valid & alu_ready;
    push      = ld_issue & ld_ready;
    pop       = mem_rvalid & (cnt != '0);
    wp_n      = (wp == PW'(LDQ_DEPTH - 1)) ? '0 : wp + 1'b1;
    rp_n      = (rp == PW'(LDQ_DEPTH - 1)) ? '0 : rp + 1'b1;
    h_dest    = q_dest[rp];
    h_type    = q_type[rp];
    h_lo      = q_lo[rp];
    byte_v    = mem_rdata[{h_lo, 3'b000} +: 8];
    half_v    = mem_rdata[{h_lo[1], 4'b0000} +: 16];
    ld_val    = h_type == 3'd0 ? {{(DW-8){byte_v[7]}}, byte_v}
              : h_type == 3'd1 ? {{(DW-8){1'b0}}, byte_v}
              : h_type == 3'd2 ? {{(DW-16){half_v[15]}}, half_v}
              : h_type == 3'd3 ? {{(DW-16){1'b0}}, half_v}
              : mem_rdata;
    // a popping load always wins; a colliding ALU result waits in the skid
    sel_v     = pop | skid_v | alu_valid;
    sel_d     = pop ? h_dest : skid_v ? skid_d : alu_dest;
    sel_data  = pop ? ld_val : skid_v ? skid_data : alu_data;
    nxt_wren  = sel_v & (sel_d != '0);
    skid_v_n  = pop ? (skid_v | alu_acc) : 1'b0;
  end
  always_comb begin
    busy = '0;
    for (int i = 0; i < LDQ_DEPTH; i++)
      busy = busy | (32'(q_v[i]) << q_dest[i]);
    ld_busy = {busy[31:1], 1'b0};
  end
`ifdef REGFILE_WB_BYPASS_EN
  always_comb begin
    byp_valid = rst & nxt_wren;
    byp_reg   = sel_d;
    byp_data  = sel_data;
  end
`endif
  always_ff @(posedge clk) begin
    if (push) begin
      q_dest[wp] <= ld_dest;
      q_type[wp] <= ld_type;
      q_lo[wp]   <= ld_lo;
    end
    if (pop & alu_acc) begin
      skid_d    <= alu_dest;
      skid_data <= alu_data;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp       <= '0;
      rp       <= '0;
      cnt      <= '0;
      q_v      <= '0;
      skid_v   <= 1'b0;
      wren     <= 1'b0;
      wr       <= '0;
      wd       <= '0;
      resp_err <= 1'b0;
    end else begin
      if (push) begin
        wp     <= wp_n;
        q_v[wp] <= 1'b1;
      end
      if (pop) begin
        rp     <= rp_n;
        q_v[rp] <= 1'b0;
      end
      cnt      <= cnt + CW'(push) - CW'(pop);
      skid_v   <= skid_v_n;
      wren     <= nxt_wren;
      wr       <= sel_d;
      wd       <= sel_data;
      resp_err <= resp_err | (mem_rvalid & (cnt == '0));
    end
  end
endmodule
